csa_stream_arb: RTL
===================

Name: csa_stream_arb

Overview:
- Round-robin arbiter and scheduler that shares one pipelined DVB-CSA stream cypher core among NUM_CH requesters.
- Each request carries a 64-bit control key (ck) and a 64-bit seed block (sb).
- The block issues at most one request per cycle to the core and tracks the core's fixed latency with a tag pipeline.
- Results (cb) are buffered in a credit-protected FIFO so the non-stallable core never overflows, and are returned with the originating channel ID.

Parameters:
- NUM_CH, 4, number of requesting channels (2..8)
- CH_W, 2, channel-ID width, equal to clog2(NUM_CH)
- LAT, 3, cycles from cy_ck/cy_sb driven to matching cy_cb valid (core input register plus init and calc stages)
- FIFO_DEPTH, 8, result FIFO entries; must be >= 2; power of two

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_CH  per-channel request valid
- req_ready  out  NUM_CH  per-channel accept, one-hot or zero
- req_ck  in  NUM_CH*64  per-channel control key; channel i at bits [64i+63:64i]
- req_sb  in  NUM_CH*64  per-channel seed block, same packing as req_ck
- cy_ck  out  64  control key to the core
- cy_sb  out  64  seed block to the core
- cy_vld  out  1  marks the cycle in which cy_ck/cy_sb hold a real request
- cy_cb  in  64  core output
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts the result
- rsp_ch  out  CH_W  channel ID of the result
- rsp_cb  out  64  cypher output block
- busy  out  1  high while any request is in flight or the FIFO is non-empty

Behaviour:
- Reset (async assert, sync release) clears the following:
  - req_ready=0, cy_ck=0, cy_sb=0, cy_vld=0
  - rsp_valid=0, rsp_ch=0, rsp_cb=0, busy=0
  - tag pipeline all-invalid, FIFO empty
  - credit=FIFO_DEPTH
  - RR pointer=NUM_CH-1, so channel 0 has first priority
- Arbitration (combinational):
  - Search starts at pointer+1, wraps modulo NUM_CH, and grants the first channel with req_valid=1.
  - A grant is allowed only when credit>0.
  - req_ready[g]=1 for the granted channel only.
  - A request is accepted when req_valid[g]&&req_ready[g].
  - The pointer updates to g on accept only.
- Issue (registered):
  - On accept at cycle T: cy_ck/cy_sb load req_ck/req_sb of channel g at T+1, cy_vld=1 at T+1.
  - With no accept, cy_vld=0 and cy_ck/cy_sb hold their last value.
- Tag pipeline:
  - LAT-stage shift register of {valid, ch}, loaded alongside cy_vld.
  - When stage LAT's valid=1, {ch, cy_cb} is pushed into the FIFO, i.e. at cycle T+1+LAT.
- Credits:
  - credit = FIFO_DEPTH - (in-flight tags + FIFO occupancy).
  - Decrement on accept; increment on FIFO pop (rsp_valid&&rsp_ready).
  - Accept and pop in the same cycle leave credit unchanged.
  - Because of the credit check, a FIFO push never finds the FIFO full. If it does, that is an error: assertion only, no hardware handling.
- FIFO:
  - First-word-fall-through from registered storage.
  - rsp_valid=1 from the cycle after the first push, so the earliest response is at T+LAT+2.
  - rsp_* stay stable while rsp_valid&&!rsp_ready.
  - Push and pop in the same cycle are both honoured.
  - Pointers wrap modulo FIFO_DEPTH.
- Ordering: responses emerge in global accept order, and therefore in per-channel order.
- Throughput: 1 request per cycle sustained while rsp_ready=1.
- busy = (any tag valid) || cy_vld || FIFO non-empty.
- Reset mid-operation: in-flight tags are discarded, the FIFO is flushed and credits are restored. Late cy_cb values are ignored.

Test Plan:
- Single request: ch2 with ck=0x0123456789ABCDEF, sb=0xE613DB6DC11C4524, rsp_ready=1.
  - req_ready[2]=1 at T; cy_vld=1 with matching cy_ck/cy_sb at T+1.
  - rsp_valid at T+LAT+2 with rsp_ch=2 and rsp_cb equal to the core model output.
- Round-robin: all 4 channels held valid for 8 cycles.
  - Grant order 0,1,2,3,0,1,2,3.
  - 8 responses with rsp_ch in the same order.
- Credit stall: rsp_ready=0, all channels valid.
  - Exactly FIFO_DEPTH (8) accepts, then req_ready=0.
  - Raising rsp_ready for 1 cycle allows exactly 1 further accept, with no lost or duplicated results.
- Simultaneous accept and pop at credit=1 (steady state) -> credit stays 1 and the FIFO count stays constant.
- Sparse requester: only ch3 valid, alternating cycles -> every request granted the cycle it is valid, and the pointer keeps ch3 fair against a later ch0 request.
- Reset mid-op: assert rst_n=0 with 3 requests in flight and 2 in the FIFO.
  - All outputs return to 0 and busy=0.
  - After release, a new ch0 request returns exactly one response.

Source files
------------

// File: rtl/csa_stream_arb.sv
// csa_stream_arb: round-robin scheduler sharing one pipelined DVB-CSA core
// among NUM_CH requesters. Issue slots are credit-limited so every result the
// non-stallable core produces is guaranteed a slot in the result FIFO.
module csa_stream_arb #(
  parameter int NUM_CH     = 4,
  parameter int CH_W       = 2,
  parameter int LAT        = 3,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_CH-1:0]    req_valid,
  output logic [NUM_CH-1:0]    req_ready,
  input  logic [NUM_CH*64-1:0] req_ck,
  input  logic [NUM_CH*64-1:0] req_sb,
  output logic [63:0]          cy_ck,
  output logic [63:0]          cy_sb,
  output logic                 cy_vld,
  input  logic [63:0]          cy_cb,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [CH_W-1:0]      rsp_ch,
  output logic [63:0]          rsp_cb,
  output logic                 busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = CH_W + 64;

  logic [CH_W-1:0] ptr_q, ptr_d;
  logic [CW-1:0]   credit_q, credit_d;
  logic [63:0]     cy_ck_q, cy_ck_d;
  logic [63:0]     cy_sb_q, cy_sb_d;
  logic            cy_vld_q, cy_vld_d;
  logic [CH_W-1:0] cy_ch_q, cy_ch_d;
  logic [LAT:1]    tag_vld_q, tag_vld_d;
  logic [CH_W-1:0] tag_ch_q [1:LAT];
  logic [CH_W-1:0] tag_ch_d [1:LAT];
  logic [EW-1:0]   mem_q [FIFO_DEPTH];
  logic [EW-1:0]   mem_d [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [CH_W-1:0] cand;
  logic [CH_W-1:0] gnt_ch;
  logic            gnt_found;
  logic            accept;
  logic            push;
  logic            pop;
  logic [63:0]     sel_ck;
  logic [63:0]     sel_sb;
  logic [EW-1:0]   head;

  // Round-robin search starting one past the last accepted channel.
  always_comb begin
    gnt_found = 1'b0;
    gnt_ch    = '0;
    cand      = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      cand = CH_W'((int'(ptr_q) + i) % NUM_CH);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_ch    = cand;
      end
    end
  end

  // A grant always targets a valid channel, so a grant is an accept.
  assign accept    = gnt_found && (credit_q != '0);
  assign req_ready = accept ? (NUM_CH'(1) << gnt_ch) : '0;

  // Mux the granted channel's key and seed block.
  always_comb begin
    sel_ck = '0;
    sel_sb = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt_ch == CH_W'(i)) begin
        sel_ck = req_ck[i*64 +: 64];
        sel_sb = req_sb[i*64 +: 64];
      end
    end
  end

  // Issue register, tag pipeline, pointer and credit next-state.
  always_comb begin
    ptr_d    = accept ? gnt_ch : ptr_q;
    cy_vld_d = accept;
    cy_ch_d  = accept ? gnt_ch : cy_ch_q;
    cy_ck_d  = accept ? sel_ck : cy_ck_q;
    cy_sb_d  = accept ? sel_sb : cy_sb_q;
    // Stage 1 follows the issue register, so stage LAT lines up with cy_cb.
    tag_vld_d[1] = cy_vld_q;
    tag_ch_d[1]  = cy_ch_q;
    for (int k = 2; k <= LAT; k++) begin
      tag_vld_d[k] = tag_vld_q[k-1];
      tag_ch_d[k]  = tag_ch_q[k-1];
    end
    credit_d = credit_q;
    if (accept && !pop) begin
      credit_d = credit_q - CW'(1);
    end else if (!accept && pop) begin
      credit_d = credit_q + CW'(1);
    end
  end

  // Result FIFO next-state: push from the last tag stage, pop on handshake.
  always_comb begin
    push     = tag_vld_q[LAT];
    pop      = rsp_valid && rsp_ready;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = {tag_ch_q[LAT], cy_cb};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push && !pop) begin
      cnt_d = cnt_q + CW'(1);
    end else if (!push && pop) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Control state with async reset; a mid-operation reset drops all tags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q     <= CH_W'(NUM_CH - 1);
      credit_q  <= CW'(FIFO_DEPTH);
      cy_ck_q   <= '0;
      cy_sb_q   <= '0;
      cy_vld_q  <= 1'b0;
      cy_ch_q   <= '0;
      tag_vld_q <= '0;
      for (int k = 1; k <= LAT; k++) begin
        tag_ch_q[k] <= '0;
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
    end else begin
      ptr_q     <= ptr_d;
      credit_q  <= credit_d;
      cy_ck_q   <= cy_ck_d;
      cy_sb_q   <= cy_sb_d;
      cy_vld_q  <= cy_vld_d;
      cy_ch_q   <= cy_ch_d;
      tag_vld_q <= tag_vld_d;
      tag_ch_q  <= tag_ch_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  // FIFO storage needs no reset: the outputs are masked while it is empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head      = mem_q[rd_ptr_q];
  assign rsp_valid = (cnt_q != '0);
  assign rsp_ch    = rsp_valid ? head[EW-1:64] : '0;
  assign rsp_cb    = rsp_valid ? head[63:0] : '0;
  assign cy_ck     = cy_ck_q;
  assign cy_sb     = cy_sb_q;
  assign cy_vld    = cy_vld_q;
  assign busy      = (|tag_vld_q) || cy_vld_q || rsp_valid;

  // Credits reserve a slot per issue, so a push can never hit a full FIFO.
  assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (cnt_q == CW'(FIFO_DEPTH))));

endmodule
